// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the instruction-memory loader.
//   - loader_state_e : loader FSM states
//   - WORD_BYTES     : bytes per instruction word (image is padded to this)
//   - IMEM_ADDR_W    : instruction memory byte-address width
//   - IMEM_DEPTH     : instruction memory size in bytes
//   - PAD_BYTE       : fill value written after a short image
package pipeline_pkg;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned IMEM_ADDR_W = 9;
    localparam int unsigned IMEM_DEPTH  = 512;
    localparam logic [7:0]  PAD_BYTE    = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPad,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Instruction memory loader: writes a valid/ready byte stream sequentially into the
// byte-addressed instruction memory starting at BASE_ADDR, zero-pads to a word boundary,
// then releases the pipeline hold.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   start       : single-cycle pulse that begins a load (ignored while loading/padding)
//   byte_valid  : byte_data valid this cycle
//   byte_data   : stream byte
//   byte_last   : final byte of the image, qualified by byte_valid
//   byte_ready  : loader accepts a byte this cycle (high only in LOAD)
//   mem_we      : registered byte write strobe
//   mem_addr    : registered write byte address
//   mem_wdata   : registered write data
//   cpu_hold    : holds the pipeline in reset while high
//   busy        : loading or padding
//   done        : image complete, pipeline released
//   overflow    : image did not fit in DEPTH bytes
//   byte_count  : stream bytes accepted in this load (pad bytes excluded)
module imem_loader
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned DEPTH     = IMEM_DEPTH,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned       AlignBits = $clog2(WORD_BYTES);
    localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [ADDR_W:0]   CountMax  = (ADDR_W + 1)'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d, wp_inc;
    logic [ADDR_W:0]   count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              word_end;

    assign wp_inc   = wp_q + ADDR_W'(1);
    // The byte at wp closes a word when the following address is word-aligned.
    assign word_end = (wp_inc[AlignBits-1:0] == '0);

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StLoad;
                    wp_d    = BaseAddr;
                    count_d = '0;
                end
            end
            StLoad: begin
                if (byte_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wp_q;
                    mem_wdata_d = byte_data;
                    wp_d        = wp_inc;
                    count_d     = (count_q == CountMax) ? count_q : count_q + 1'b1;
                    if (byte_last) begin
                        state_d = word_end ? StDone : StPad;
                    end else if (wp_q == LastAddr) begin
                        // Last location just written and more data still expected.
                        state_d = StError;
                    end
                end
            end
            StPad: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wp_q;
                mem_wdata_d = PAD_BYTE;
                wp_d        = wp_inc;
                if (word_end) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so the hold drops exactly on entry to DONE.
        cpu_hold_d = (state_d != StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wp_q        <= BaseAddr;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BaseAddr;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign byte_ready = (state_q == StLoad);
    assign busy       = (state_q == StLoad) || (state_q == StPad);
    assign done       = (state_q == StDone);
    assign overflow   = (state_q == StError);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default parameters: 512 bytes, base 0).
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [9:0] byte_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [8:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t wlog[$];
    int  cyc = 0;

    imem_loader dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side write log: registered outputs seen at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) wlog.push_back('{mem_addr, mem_wdata, cyc});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one cycle of inputs from a falling edge, then return them to idle.
    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
        byte_valid = v;
        byte_data  = d;
        byte_last  = l;
        start      = s;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total_cnt++;
        if ({cpu_hold, byte_ready, mem_we, busy, done, overflow} !== 6'b100000)
            $display("FAIL reset_flags: got %b want 100000",
                     {cpu_hold, byte_ready, mem_we, busy, done, overflow});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 9'd0 || mem_wdata !== 8'h00 || byte_count !== 10'd0)
            $display("FAIL reset_regs: addr %0h wdata %0h count %0d want 0 0 0",
                     mem_addr, mem_wdata, byte_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // start together with a valid byte in IDLE: byte must not be taken
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        start      = 1'b1;
        #1;
        total_cnt++;
        if (byte_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", byte_ready);
        else pass_cnt++;
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        total_cnt++;
        if (mem_we !== 1'b0 || busy !== 1'b1 || byte_count !== 10'd0)
            $display("FAIL idle_start_collision: we %b busy %b count %0d want 0 1 0",
                     mem_we, busy, byte_count);
        else pass_cnt++;
    endtask

    task automatic test_aligned;
        int errs;
        wlog.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), (i == 7), 1'b0);
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || byte_count !== 10'd8 || mem_we !== 1'b0)
            $display("FAIL aligned_done: done %b hold %b count %0d we %b want 1 0 8 0",
                     done, cpu_hold, byte_count, mem_we);
        else pass_cnt++;
        @(negedge clk);
        errs = 0;
        if (wlog.size() != 8) errs++;
        else for (int i = 0; i < 8; i++)
            if (wlog[i].a !== 9'(i) || wlog[i].d !== 8'(i) || wlog[i].c != wlog[0].c + i)
                errs++;
        total_cnt++;
        if (errs != 0)
            $display("FAIL aligned_writes: %0d bad, %0d logged, want 8 writes addr=data=0..7",
                     errs, wlog.size());
        else pass_cnt++;
    endtask

    task automatic test_pad;
        int errs;
        logic [7:0] exp_d;
        wlog.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0 + 8'(i), (i == 4), 1'b0);
        total_cnt++;
        if (busy !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL pad_state: busy %b ready %b done %b want 1 0 0",
                     busy, byte_ready, done);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || byte_count !== 10'd5)
            $display("FAIL pad_done: done %b hold %b count %0d want 1 0 5",
                     done, cpu_hold, byte_count);
        else pass_cnt++;
        @(negedge clk);
        errs = 0;
        if (wlog.size() != 8) errs++;
        else for (int i = 0; i < 8; i++) begin
            exp_d = (i < 5) ? 8'hA0 + 8'(i) : 8'h00;
            if (wlog[i].a !== 9'(i) || wlog[i].d !== exp_d || wlog[i].c != wlog[0].c + i)
                errs++;
        end
        total_cnt++;
        if (errs != 0)
            $display("FAIL pad_writes: %0d bad, %0d logged, want A0..A4 then 00 x3 at 0..7",
                     errs, wlog.size());
        else pass_cnt++;
    endtask

    task automatic test_gaps;
        logic [6:0] vpat;
        logic [7:0] exp_d [4];
        int errs;
        vpat = 7'b1011001; // bit i = valid in cycle i: 1,0,0,1,1,0,1
        exp_d = '{8'h10, 8'h13, 8'h14, 8'h16};
        wlog.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(vpat[i], 8'h10 + 8'(i), (i == 6), 1'b0);
            total_cnt++;
            if (mem_we !== vpat[i])
                $display("FAIL gaps_we cycle %0d: got %b want %b", i, mem_we, vpat[i]);
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
        errs = 0;
        if (wlog.size() != 4) errs++;
        else for (int i = 0; i < 4; i++)
            if (wlog[i].a !== 9'(i) || wlog[i].d !== exp_d[i]) errs++;
        total_cnt++;
        if (errs != 0 || done !== 1'b1)
            $display("FAIL gaps_writes: %0d bad, %0d logged, done %b want 4 writes 0..3, done 1",
                     errs, wlog.size(), done);
        else pass_cnt++;
    endtask

    task automatic test_start_in_load;
        int errs;
        wlog.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h30 + 8'(i), (i == 7), (i == 2));
        repeat (2) @(negedge clk);
        errs = 0;
        if (wlog.size() != 8) errs++;
        else for (int i = 0; i < 8; i++)
            if (wlog[i].a !== 9'(i) || wlog[i].d !== 8'h30 + 8'(i)) errs++;
        total_cnt++;
        if (errs != 0)
            $display("FAIL start_in_load_writes: %0d bad, %0d logged, want addr 0..7 unbroken",
                     errs, wlog.size());
        else pass_cnt++;
        total_cnt++;
        if (byte_count !== 10'd8 || done !== 1'b1)
            $display("FAIL start_in_load_count: count %0d done %b want 8 1", byte_count, done);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        int errs;
        wlog.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 512; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        total_cnt++;
        if (overflow !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL ovf_state: ovf %b hold %b ready %b busy %b want 1 1 0 0",
                     overflow, cpu_hold, byte_ready, busy);
        else pass_cnt++;
        total_cnt++;
        if (byte_count !== 10'd512)
            $display("FAIL ovf_count: got %0d want 512", byte_count);
        else pass_cnt++;
        drive(1'b1, 8'hFF, 1'b0, 1'b0); // byte 512 must be refused
        total_cnt++;
        if (mem_we !== 1'b0 || byte_count !== 10'd512)
            $display("FAIL ovf_refuse: we %b count %0d want 0 512", mem_we, byte_count);
        else pass_cnt++;
        @(negedge clk);
        errs = 0;
        if (wlog.size() != 512) errs++;
        else for (int i = 0; i < 512; i++)
            if (wlog[i].a !== 9'(i) || wlog[i].d !== 8'(i)) errs++;
        total_cnt++;
        if (errs != 0)
            $display("FAIL ovf_writes: %0d bad, %0d logged, want 512 writes addr i data i",
                     errs, wlog.size());
        else pass_cnt++;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        total_cnt++;
        if (overflow !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1 || byte_count !== 10'd0)
            $display("FAIL ovf_restart: ovf %b busy %b ready %b count %0d want 0 1 1 0",
                     overflow, busy, byte_ready, byte_count);
        else pass_cnt++;
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (wlog.size() != 516 || wlog[512].a !== 9'd0 || wlog[512].d !== 8'h5A ||
            wlog[515].a !== 9'd3 || done !== 1'b1)
            $display("FAIL ovf_reload: %0d logged, done %b want 516 logged, 5A at 0, pad to 3",
                     wlog.size(), done);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0 || byte_count !== 10'd0 || cpu_hold !== 1'b1 || mem_addr !== 9'd0)
            $display("FAIL midreset_regs: we %b count %0d hold %b addr %0h want 0 0 1 0",
                     mem_we, byte_count, cpu_hold, mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL midreset_state: busy %b done %b ready %b want 0 0 0",
                     busy, done, byte_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (wlog.size() != 0 || busy !== 1'b0)
            $display("FAIL midreset_quiet: %0d writes busy %b want 0 writes busy 0",
                     wlog.size(), busy);
        else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        @(negedge clk);
        test_reset();
        test_aligned();
        test_pad();
        test_gaps();
        test_start_in_load();
        test_overflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed instruction memory that the pipeline fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and writes the bytes sequentially into instruction memory from BASE_ADDR.
- Zero-pads the image to a 4-byte word boundary, then releases the pipeline hold so fetch starts from a complete image.
- Replaces file-based preload for synthesizable bring-up.

Parameters:
ADDR_W, 9, instruction memory byte-address width
DEPTH, 512, memory size in bytes; must be a multiple of 4 and at most 2**ADDR_W
BASE_ADDR, 0, first byte address written; must be word-aligned

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a load
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_last  input  1  qualifies the final byte of the image; sampled with byte_valid
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  byte write strobe to instruction memory
mem_addr  output  ADDR_W  write byte address
mem_wdata  output  8  write data
cpu_hold  output  1  holds the pipeline (PC/nPC) in reset while high
busy  output  1  high in LOAD or PAD
done  output  1  high in DONE
overflow  output  1  high in ERROR
byte_count  output  ADDR_W+1  stream bytes accepted in the current load; excludes pad bytes

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, cpu_hold=1.
  - byte_ready, mem_we, busy, done, overflow all 0.
  - mem_addr=BASE_ADDR, mem_wdata=0, byte_count=0.
- States: IDLE, LOAD, PAD, DONE, ERROR.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - start -> LOAD; internal write pointer wp=BASE_ADDR, byte_count=0.
- LOAD:
  - byte_ready=1 combinationally from state; it never depends on byte_valid.
  - Accept when byte_valid && byte_ready.
  - Each accept registers mem_we=1, mem_addr=wp, mem_wdata=byte_data. The write appears the cycle after acceptance, with exactly one mem_we pulse per accepted byte.
  - Each accept also sets wp=wp+1 and byte_count+1.
  - No accept in a cycle -> mem_we=0 the next cycle.
  - Accept with byte_last and (wp+1) word-aligned -> DONE.
  - Accept with byte_last and (wp+1) unaligned -> PAD.
  - Accept without byte_last when wp == BASE_ADDR+DEPTH-1 -> ERROR. That final byte is still written.
  - Any byte_valid arriving in ERROR is never accepted.
  - start in LOAD is ignored.
- PAD:
  - byte_ready=0.
  - One zero byte written per cycle at wp (mem_we=1, mem_wdata=0x00), wp+1.
  - Leaves for DONE in the cycle the last pad byte is issued, i.e. when (wp+1)[1:0]==0.
  - Pads 1–3 bytes; never overruns, because DEPTH is a multiple of 4.
- DONE:
  - cpu_hold=0 (registered, deasserts on entry), done=1.
  - byte_ready=0; mem_addr and mem_wdata hold their last values.
  - start -> LOAD with cpu_hold=1, pointers and count reinitialised, done=0.
- ERROR:
  - overflow=1, cpu_hold=1, byte_ready=0.
  - start -> LOAD with reinitialisation, as in DONE.
- Simultaneous events:
  - start together with byte_valid in IDLE: the byte is not accepted (byte_ready=0 in IDLE).
  - Reset mid-LOAD/PAD: immediate return to IDLE with the reset values; any partial image in memory is left as is.
- Widths:
  - wp arithmetic is modulo 2**ADDR_W, but the overflow check makes wrap unreachable.
  - byte_count saturates at DEPTH, which is never exceeded.

Decomposition:
- Shared package (pipeline_pkg): the state enumeration (IDLE/LOAD/PAD/DONE/ERROR), WORD_BYTES=4, IMEM_ADDR_W=9, IMEM_DEPTH=512, PAD_BYTE=8'h00.
- No sub-module: FSM plus write pointer fit in a single module.

Test Plan:
- Load 8 bytes 0x00..0x07 with valid held high and last on byte 7:
  - writes addr 0..7 with matching data, one per cycle, one cycle after each accept.
  - no PAD; done=1 and cpu_hold=0 the cycle after the addr 7 write; byte_count=8.
- Load 5 bytes 0xA0..0xA4:
  - data written at addr 0..4, then 0x00 at addr 5, 6, 7 on three consecutive cycles.
  - done=1 after the addr 7 write; byte_count=5.
- Valid with gaps (valid pattern 1,0,0,1,1,0,1 with last):
  - mem_we pulses only after accepting cycles; addresses contiguous 0..3; no duplicate or dropped writes.
- Stream 513 bytes with no last:
  - bytes 0..511 written to addr 0..511; overflow=1 after byte 511.
  - byte 512 is never accepted; cpu_hold=1; a following start re-enters LOAD at addr 0 with overflow=0.
- Reset low for one cycle after byte 3 of a load:
  - immediately state IDLE, mem_we=0, byte_count=0, cpu_hold=1, mem_addr=BASE_ADDR.
  - no further writes until start.
- start pulsed during LOAD at byte 2:
  - ignored; addresses continue 3, 4, … without restarting at 0.
